// File: rtl/device_event_serialiser_pkg.sv
// Shared definitions for the active IoT devices monitor path: default device
// count, derived widths and the popcount used by both the serialiser and the monitor bench.
package iot_pkg;

    localparam int N_DEV_DEFAULT = 8;

    function automatic int dev_id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

    // Wide enough for the largest supported N_DEV (32).
    function automatic int popcount(input logic [31:0] v);
        int c;
        c = 0;
        for (int i = 0; i < 32; i++) begin
            c = c + int'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/device_event_serialiser_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester found scanning
// upward from ptr+1, wrapping modulo N so unused indices are never granted.
module rr_arbiter #(
    parameter int N     = 8,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    input  logic             en,
    output logic             gnt_valid,
    output logic [IDX_W-1:0] gnt_idx
);

    always_comb begin
        int idx;
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        idx       = 0;
        for (int off = 1; off <= N; off++) begin
            idx = int'(ptr) + off;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (en && !gnt_valid && req[IDX_W'(idx)]) begin
                gnt_valid = 1'b1;
                gnt_idx   = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/device_event_serialiser.sv
// Turns per-device on/off status changes into one change/on_off pulse per cycle
// for the up/down active-device counter, arbitrating simultaneous changes round-robin.
module device_event_serialiser
    import iot_pkg::*;
#(
    parameter int N_DEV    = N_DEV_DEFAULT,
    parameter int DEV_ID_W = dev_id_width(N_DEV),
    parameter int CNT_W    = cnt_width(N_DEV)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_DEV-1:0]    dev_status,
    input  logic                enable,
    output logic                change,
    output logic                on_off,
    output logic [DEV_ID_W-1:0] dev_id,
    output logic [CNT_W-1:0]    pending_cnt
);

    logic [N_DEV-1:0]    sync1_q, sync2_q;
    logic [N_DEV-1:0]    tracked_q, tracked_d;
    logic [DEV_ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic                change_q, change_d;
    logic                on_off_q, on_off_d;
    logic [DEV_ID_W-1:0] dev_id_q, dev_id_d;
    logic [CNT_W-1:0]    pending_cnt_q, pending_cnt_d;

    logic [N_DEV-1:0]    pending;
    logic                gnt_valid;
    logic [DEV_ID_W-1:0] gnt_idx;

    // A device is pending while its synchronised status differs from what was last reported.
    assign pending = sync2_q ^ tracked_q;

    rr_arbiter #(
        .N     (N_DEV),
        .IDX_W (DEV_ID_W)
    ) u_arb (
        .req       (pending),
        .ptr       (rr_ptr_q),
        .en        (enable),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    always_comb begin
        tracked_d     = tracked_q;
        rr_ptr_d      = rr_ptr_q;
        change_d      = 1'b0;
        on_off_d      = on_off_q;
        dev_id_d      = dev_id_q;
        pending_cnt_d = CNT_W'(popcount(32'(pending)));
        if (gnt_valid) begin
            tracked_d[gnt_idx] = sync2_q[gnt_idx];
            rr_ptr_d           = gnt_idx;
            change_d           = 1'b1;
            on_off_d           = sync2_q[gnt_idx];
            dev_id_d           = gnt_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            tracked_q     <= '0;
            rr_ptr_q      <= DEV_ID_W'(N_DEV - 1);
            change_q      <= 1'b0;
            on_off_q      <= 1'b0;
            dev_id_q      <= '0;
            pending_cnt_q <= '0;
        end else begin
            sync1_q       <= dev_status;
            sync2_q       <= sync1_q;
            tracked_q     <= tracked_d;
            rr_ptr_q      <= rr_ptr_d;
            change_q      <= change_d;
            on_off_q      <= on_off_d;
            dev_id_q      <= dev_id_d;
            pending_cnt_q <= pending_cnt_d;
        end
    end

    assign change      = change_q;
    assign on_off      = on_off_q;
    assign dev_id      = dev_id_q;
    assign pending_cnt = pending_cnt_q;

endmodule

// File: doc/device_event_serialiser.md
Name: device_event_serialiser

Overview:
- Upstream stage of the active IoT devices monitor (the up/down active-device counter).
- Watches a vector of per-device on/off status lines and converts every net status change into a single-cycle change/on_off pulse.
- Issues at most one event per cycle, so the monitor's counter_out always converges to the number of devices currently on.
- Uses a round-robin arbiter when several devices change together.

Parameters:
- N_DEV, 8, number of monitored devices (2..32).
- DEV_ID_W, $clog2(N_DEV), width of dev_id.
- CNT_W, $clog2(N_DEV+1), width of pending_cnt.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-high; shared with the monitor.
- dev_status  in  N_DEV  per-device status, 1 = on; may be asynchronous.
- enable  in  1  event issue permitted; when low, events are held, not dropped.
- change  out  1  one-cycle pulse, one device event; drives the monitor's change.
- on_off  out  1  event polarity, 1 = device turned on; drives the monitor's on_off.
- dev_id  out  DEV_ID_W  index of the device reported by the current change pulse.
- pending_cnt  out  CNT_W  number of devices whose status differs from last reported state.

Behaviour:
- Reset (rst=1 at rising edge):
  - sync1, sync2 and tracked all go to 0.
  - change=0, on_off=0, dev_id=0, pending_cnt=0.
  - rr_ptr goes to N_DEV-1, so the first search starts at device 0.
- Synchroniser: 2-flop per bit, dev_status -> sync1 -> sync2.
- pending[i] = sync2[i] XOR tracked[i] (combinational).
- Toggling back before the event issues cancels it with no pulse; net count stays correct.
- Grant (per cycle): if enable=1 and pending != 0, pick the first pending index scanning from rr_ptr+1 upward, modulo N_DEV. At the next rising edge:
  - change=1, on_off=sync2[g], dev_id=g.
  - tracked[g] <= sync2[g], rr_ptr <= g.
- Otherwise change=0; on_off and dev_id hold their last values.
- change is never high for two events on the same device without an intervening status change.
- Back-to-back pulses on consecutive cycles are legal, one per cycle.
- Latency, uncontended: dev_status[i] changes and is stable before edge E0; change=1 for the cycle after E2, i.e. exactly 3 edges.
- With k pending devices, the last one issues within k cycles after its sync2 update.
- pending_cnt: registered popcount(pending), one cycle behind pending.
- enable low: pending accumulates, no pulses, rr_ptr frozen; issuing resumes the cycle after enable returns high.
- Reset mid-operation: all state clears, so devices still on reappear as pending once sync2 reflects them. The monitor resets on the same rst, so both restart from 0 and reconverge.
- Invariant: popcount(tracked) equals the monitor's counter_out at every cycle, given the monitor counts on change.
- N_DEV not a power of 2: the modulo wrap skips unused indices; dev_id never exceeds N_DEV-1.

Decomposition:
- Package iot_pkg holds:
  - default N_DEV;
  - DEV_ID_W and CNT_W derivation;
  - a popcount function shared with the monitor bench.
- Sub-module rr_arbiter (N parameter):
  - inputs: req[N], ptr, en;
  - outputs: gnt_valid, gnt_idx;
  - purely combinational priority rotation.
- The top module holds the synchroniser, tracked register, output registers and rr_ptr.

Test Plan:
- Reset: rst=1 for 5 cycles with dev_status=8'hFF -> change=0, pending_cnt=0 throughout. After release, exactly 8 pulses on dev_id 0..7 in order, all on_off=1, on consecutive cycles; a chained monitor reads 8.
- Single event: dev_status 8'h00->8'h04 and held -> one pulse 3 edges later with dev_id=2, on_off=1. Then 8'h04->8'h00 -> one pulse with dev_id=2, on_off=0.
- Contention/fairness: after last grant dev_id=5, dev_status 8'h00->8'hA1 simultaneously -> pulses in order dev_id=7,0,5 on consecutive cycles; pending_cnt goes 3,2,1,0.
- Cancellation: hold enable=0; toggle bit 3 on then off after 4 cycles; raise enable -> no change pulse, pending_cnt 1 then 0.
- Enable hold: enable=0, dev_status 8'h00->8'h0F -> no pulses, pending_cnt=4. enable=1 -> 4 pulses dev_id=0..3 starting the next cycle.
- Mid-operation reset: rst pulsed one cycle while 3 events are pending -> outputs 0 next cycle. Afterwards the pulse count equals popcount(dev_status) and the chained monitor counter equals popcount(dev_status).
